down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Synchronous, loadable down-counter/timer. It counts from a loaded value toward zero and pulses a terminal-count flag when it expires.
- Complements the team's ripple up-counters. Used for programmable delays, timeouts and periodic ticks.
- Supports one-shot and auto-reload modes.
- Fully synchronous: every state element samples on the rising edge of clk.

Parameters:
- W, 4, counter and load-value width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk; rst=0 resets the block.
- en  input  1  count enable; one decrement per enabled cycle while running.
- load  input  1  load strobe; captures load_val into the counter and the reload register.
- load_val  input  W  start/reload value.
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle.
- q  output  W  current count (registered).
- tc  output  1  terminal-count pulse, one cycle wide (registered).
- busy  output  1  high while the FSM is in RUN (registered).

Behaviour:
- Reset (rst=0 at a rising edge): q=0, reload_reg=0, state=IDLE, tc=0, busy=0. Reset overrides load and en.
- FSM states:
  - IDLE: holds q; en is ignored.
  - RUN: counts down.
- Priority, highest first: reset, load, count, hold.
- load=1, in any state:
  - q<=load_val and reload_reg<=load_val; tc<=0.
  - load_val!=0: state<=RUN. load_val==0: state<=IDLE.
  - Latency: q and busy reflect the load one cycle after the strobe edge.
- RUN, en=1, q>1: q<=q-1; tc<=0.
- RUN, en=1, q==1, mode=0: q<=0; state<=IDLE; tc<=1.
- RUN, en=1, q==1, mode=1:
  - q<=reload_reg; state stays RUN; tc<=1.
  - q never shows 0 in auto-reload, so the tc period is reload_reg enabled cycles.
- RUN, en=0: q holds; tc<=0.
- IDLE, no load: q holds; tc<=0.
- Boundary cases:
  - reload_reg==1 in auto-reload: q stays 1 and tc=1 on every enabled cycle.
  - load coincident with the expiry cycle: load wins; no tc pulse.
  - mode changed mid-count: takes effect at the next q==1 expiry.
  - Reset mid-count: the count is abandoned; all outputs reset on that edge; tc never pulses.
  - q==0 while in RUN is unreachable; an implementation must still hold q and force IDLE if it occurs.
- Arithmetic: unsigned, W bits. A decrement below 0 never occurs.
- Derived signal: busy = (state==RUN).

Decomposition:
- Shared package timer_pkg:
  - State encoding localparams ST_IDLE=1'b0 and ST_RUN=1'b1.
  - Mode constants MODE_ONESHOT=0 and MODE_RELOAD=1.
- A single module is sufficient; no sub-module is required.
- Datapath (counter plus reload register) and the two-state FSM live in one always block, or in separate next-state and register blocks.

Test Plan:
- Reset: hold rst=0 for 2 cycles with load=1 and load_val=4'hA -> q=0, tc=0, busy=0. Release rst -> outputs unchanged.
- One-shot: load 4'd3 with mode=0, then en=1 continuously -> q=3,2,1,0 on successive cycles.
  - tc=1 only in the cycle q becomes 0.
  - busy drops with it and q stays 0 afterwards.
- Auto-reload: load 4'd4 with mode=1, en=1 for 12 cycles -> q=4,3,2,1,4,3,2,1,4,...
  - tc pulses exactly every 4th cycle, aligned with q returning to 4.
- Enable gating: load 4'd5, then toggle en 1,0,0,1,1 -> q=4,4,4,3,2; tc stays 0 throughout.
- Load collision: q==1 in RUN with mode=0, then assert load=1 with load_val=4'd7 and en=1 on the same edge -> q=7, tc=0, busy=1.
- Edge values:
  - load 4'd0 -> busy=0, tc never asserts.
  - Auto-reload with load 4'd1 -> tc=1 on every enabled cycle.
  - Load 4'hF -> 15 enabled cycles before tc.
  - Reset asserted mid-count at q=6 -> q=0 on the next edge, with no tc.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the down_timer block: FSM state encoding and mode constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

   // Raw state encoding. The enum below is built on top of these values.
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   // Value of the mode input.
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN
   } state_t;

endpackage : timer_pkg

// File: rtl/down_timer.sv
// Loadable W-bit down-counter with one-shot / auto-reload terminal-count pulse.
// Latency: load visible on q/busy one cycle after the strobe edge; tc registered with the expiry.
// Backpressure: none; en simply stalls the count and load always wins over counting.
//
// Ports:
//   i_clk      rising-edge clock for all state
//   i_rst      synchronous active-low reset (0 = reset)
//   i_en       count enable; one decrement per enabled cycle while running
//   i_load     load strobe; captures i_load_val into the count and the reload register
//   i_load_val start / reload value
//   i_mode     0 = one-shot, 1 = auto-reload; sampled every cycle
//   o_q        current count
//   o_tc       one-cycle terminal-count pulse
//   o_busy     high while the timer is running
module down_timer
   import timer_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_mode,
   output logic [W-1:0] o_q,
   output logic         o_tc,
   output logic         o_busy
);

   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ZERO = '0;

   state_t         r_state;
   logic [W-1:0]   r_q;
   logic [W-1:0]   r_reload;
   logic           r_tc;

   state_t         w_state_nxt;
   logic [W-1:0]   w_q_nxt;
   logic [W-1:0]   w_reload_nxt;
   logic           w_tc_nxt;

   // Next-state / datapath. Priority: load, then count, then hold.
   always_comb begin
      w_state_nxt  = r_state;
      w_q_nxt      = r_q;
      w_reload_nxt = r_reload;
      w_tc_nxt     = 1'b0;

      if (i_load) begin
         w_q_nxt      = i_load_val;
         w_reload_nxt = i_load_val;
         // Loading zero leaves nothing to count, so stay idle.
         w_state_nxt  = (i_load_val != ZERO) ? S_RUN : S_IDLE;
      end else if (r_state == S_RUN) begin
         if (r_q == ZERO) begin
            // Should never be reached; recover by parking in IDLE with q held.
            w_state_nxt = S_IDLE;
         end else if (i_en) begin
            if (r_q > ONE) begin
               w_q_nxt = r_q - ONE;
            end else begin
               // Expiry: q==1 on an enabled cycle.
               w_tc_nxt = 1'b1;
               if (i_mode == MODE_RELOAD) begin
                  // Skip zero entirely so the tc period equals the reload value.
                  w_q_nxt = r_reload;
               end else begin
                  w_q_nxt     = ZERO;
                  w_state_nxt = S_IDLE;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state  <= S_IDLE;
         r_q      <= ZERO;
         r_reload <= ZERO;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_q      <= w_q_nxt;
         r_reload <= w_reload_nxt;
         r_tc     <= w_tc_nxt;
      end
   end

   assign o_q    = r_q;
   assign o_tc   = r_tc;
   assign o_busy = (r_state == S_RUN);

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed literal scenarios plus randomized traffic,
// with every cycle compared against a behavioural model of the timer.
// Inputs change 1 time unit after each rising edge; outputs are compared on the falling edge.
module tb_down_timer;

   localparam int W = 4;

   logic         i_clk;
   logic         i_rst;
   logic         i_en;
   logic         i_load;
   logic [W-1:0] i_load_val;
   logic         i_mode;
   logic [W-1:0] o_q;
   logic         o_tc;
   logic         o_busy;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Behavioural model state.
   int m_q      = 0;
   int m_reload = 0;
   bit m_run    = 1'b0;
   bit m_tc     = 1'b0;

   down_timer #(.W(W)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_load     (i_load),
      .i_load_val (i_load_val),
      .i_mode     (i_mode),
      .o_q        (o_q),
      .o_tc       (o_tc),
      .o_busy     (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a timer that counts the loaded value down to one, then either stops at zero
   // (one-shot) or jumps back to the loaded value (auto-reload), flagging each expiry.
   always @(posedge i_clk) begin
      m_tc = 1'b0;
      if (i_rst !== 1'b1) begin
         m_q = 0; m_reload = 0; m_run = 1'b0;
      end else if (i_load) begin
         m_q = int'(i_load_val);
         m_reload = m_q;
         m_run = (m_q != 0);
      end else if (m_run && m_q == 0) begin
         m_run = 1'b0;
      end else if (m_run && i_en) begin
         if (m_q == 1) begin
            m_tc = 1'b1;
            if (i_mode) m_q = m_reload;
            else begin
               m_q = 0;
               m_run = 1'b0;
            end
         end else begin
            m_q = m_q - 1;
         end
      end
   end

   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("model_q",    int'(o_q),    m_q);
         chk("model_tc",   int'(o_tc),   int'(m_tc));
         chk("model_busy", int'(o_busy), int'(m_run));
      end
   end

   task automatic cyc(input logic r, input logic ld, input int lv, input logic md, input logic e);
      i_rst      = r;
      i_load     = ld;
      i_load_val = lv[W-1:0];
      i_mode     = md;
      i_en       = e;
      @(posedge i_clk);
      #1;
   endtask

   task automatic expect3(input string name, input int q, input int tc, input int busy);
      chk({name, "_q"},    int'(o_q),    q);
      chk({name, "_tc"},   int'(o_tc),   tc);
      chk({name, "_busy"}, int'(o_busy), busy);
   endtask

   initial begin
      int ar_q [12];
      int n_tc;
      bit seen;

      i_rst = 1'b0; i_load = 1'b1; i_load_val = 4'hA; i_mode = 1'b0; i_en = 1'b0;

      // Reset dominates load.
      cyc(1'b0, 1'b1, 'hA, 1'b0, 1'b0);
      chk_en = 1'b1;
      cyc(1'b0, 1'b1, 'hA, 1'b0, 1'b0);
      expect3("reset", 0, 0, 0);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
      expect3("reset_release", 0, 0, 0);

      // One-shot from 3.
      cyc(1'b1, 1'b1, 3, 1'b0, 1'b0);
      expect3("os_load", 3, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
      expect3("os_2", 2, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
      expect3("os_1", 1, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
      expect3("os_0", 0, 1, 0);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
      expect3("os_hold", 0, 0, 0);

      // Auto-reload from 4, twelve enabled cycles.
      ar_q = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
      cyc(1'b1, 1'b1, 4, 1'b1, 1'b0);
      expect3("ar_load", 4, 0, 1);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
         expect3("ar_step", ar_q[i], (ar_q[i] == 4) ? 1 : 0, 1);
      end

      // Enable gating.
      cyc(1'b1, 1'b1, 5, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1); expect3("gate_a", 4, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); expect3("gate_b", 4, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); expect3("gate_c", 4, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1); expect3("gate_d", 3, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1); expect3("gate_e", 2, 0, 1);

      // Load collides with the expiry edge.
      cyc(1'b1, 1'b1, 2, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1); expect3("coll_pre", 1, 0, 1);
      cyc(1'b1, 1'b1, 7, 1'b0, 1'b1); expect3("coll", 7, 0, 1);

      // Loading zero stays idle.
      cyc(1'b1, 1'b1, 0, 1'b0, 1'b1); expect3("zero_load", 0, 0, 0);
      cyc(1'b1, 1'b0, 0, 1'b1, 1'b1); expect3("zero_hold", 0, 0, 0);

      // Auto-reload with 1: tc on every enabled cycle.
      cyc(1'b1, 1'b1, 1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
         expect3("ar1", 1, 1, 1);
      end

      // Mode switched mid-count takes effect at the next expiry.
      cyc(1'b1, 1'b1, 3, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1); expect3("mode_sw_1", 1, 0, 1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1); expect3("mode_sw_exp", 0, 1, 0);

      // Load 15: tc on the 15th enabled cycle (bounded wait).
      cyc(1'b1, 1'b1, 15, 1'b0, 1'b0);
      n_tc = 0;
      seen = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
         if (o_tc) begin
            seen = 1'b1;
            n_tc = i;
         end
      end
      chk("max_cycles_to_tc", n_tc, 15);

      // Reset mid-count at q=6.
      cyc(1'b1, 1'b1, 9, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
      chk("mid_q6", int'(o_q), 6);
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1); expect3("mid_rst", 0, 0, 0);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1); expect3("mid_after", 0, 0, 0);

      // Randomized traffic, checked every cycle by the model compare.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
             ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0);
      end

      @(negedge i_clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_down_timer
